// File: rtl/diode_deframer.sv
// Deframes the one-way diode word stream into header/payload/trailer packets.
// Payload is forwarded with zero latency; each frame gets a checksum and overflow verdict.
module diode_deframer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MAX_LEN = 16,
  parameter logic [15:0] MAGIC   = 16'hA55A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             in_overflow,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             frame_done,
  output logic             frame_ok,
  output logic [15:0]      good_count,
  output logic [15:0]      bad_count,
  output logic [15:0]      resync_count
);

  localparam int unsigned LEN_W = 16;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] PAYLOAD = 2'd1;
  localparam logic [1:0] TRAILER = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [LEN_W-1:0] remaining;
  logic [WIDTH-1:0] sum;
  logic             err;
  logic [LEN_W-1:0] hdr_len;
  logic             hdr_ok;
  logic             take;
  logic [WIDTH-1:0] trailer_sum;
  logic             trailer_good;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  assign hdr_len      = in_data[LEN_W-1:0];
  assign hdr_ok       = (in_data[WIDTH-1:WIDTH-16] == MAGIC) && (hdr_len != '0) &&
                        (32'(hdr_len) <= MAX_LEN);
  assign take         = in_valid && in_ready;
  assign trailer_sum  = sum + in_data;
  assign trailer_good = (trailer_sum == '0) && !err && !in_overflow;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_next;
  end

  // Next state and handshake; in_ready never looks at in_valid, so no loop
  always_comb begin
    state_next = state;
    in_ready   = 1'b1;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    case (state)
      HUNT: begin
        if (in_valid && hdr_ok) state_next = PAYLOAD;
      end
      PAYLOAD: begin
        in_ready  = out_ready;
        out_valid = in_valid;
        out_data  = in_data;
        out_last  = (remaining == LEN_W'(1));
        if (in_valid && out_ready && (remaining == LEN_W'(1))) state_next = TRAILER;
      end
      TRAILER: begin
        if (in_valid) state_next = HUNT;
      end
      default: state_next = HUNT;
    endcase
  end

  // Frame accumulator, verdict pulse and saturating statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining    <= '0;
      sum          <= '0;
      err          <= 1'b0;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
      good_count   <= '0;
      bad_count    <= '0;
      resync_count <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      if (take) begin
        case (state)
          HUNT: begin
            if (hdr_ok) begin
              remaining <= hdr_len;
              sum       <= in_data;
              err       <= in_overflow;
            end else begin
              resync_count <= sat_inc(resync_count);
            end
          end
          PAYLOAD: begin
            remaining <= remaining - LEN_W'(1);
            sum       <= sum + in_data;
            err       <= err | in_overflow;
          end
          TRAILER: begin
            frame_done <= 1'b1;
            frame_ok   <= trailer_good;
            if (trailer_good) good_count <= sat_inc(good_count);
            else              bad_count  <= sat_inc(bad_count);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_diode_deframer.sv
// Bench for diode_deframer: directed test-plan scenarios plus random streams
// scored against a frame-level reference model.
module tb_diode_deframer;

  localparam logic [15:0] MAGIC = 16'hA55A;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        in_overflow;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        frame_done;
  logic        frame_ok;
  logic [15:0] good_count;
  logic [15:0] bad_count;
  logic [15:0] resync_count;

  int checks = 0;
  int errors = 0;

  logic [32:0] o_out[$];
  logic [32:0] m_out[$];
  bit          o_ok[$];
  bit          m_ok[$];

  diode_deframer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .frame_done(frame_done), .frame_ok(frame_ok),
    .good_count(good_count), .bad_count(bad_count), .resync_count(resync_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe sink transfers and verdict pulses once per cycle, mid-low-phase
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (out_valid && out_ready) o_out.push_back({out_last, out_data});
      if (frame_done) o_ok.push_back(frame_ok);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_overflow = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    o_out.delete(); o_ok.delete(); m_out.delete(); m_ok.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; in_overflow = 1'b0; out_ready = 1'b1;
    end
  endtask

  // Present one word until accepted, with optional random gaps and sink stalls
  task automatic drive_word(input logic [31:0] d, input bit ov, input int stall_pct,
                            input int gap_pct);
    int n;
    n = 0;
    @(negedge clk);
    while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct && n < 3) begin
      in_valid = 1'b0; in_overflow = 1'b0;
      out_ready = int'($urandom_range(99)) >= stall_pct;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1; in_data = d; in_overflow = ov;
    out_ready = int'($urandom_range(99)) >= stall_pct;
    #1;
    n = 0;
    while (!in_ready) begin
      if (n >= 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout: word %h not accepted, in_ready=%b", d, in_ready);
        break;
      end
      @(negedge clk);
      out_ready = int'($urandom_range(99)) >= stall_pct;
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      errors++; $display("FAIL reset_out: out_valid=%b out_last=%b want 0 0", out_valid, out_last);
    end
    checks++;
    if (frame_done !== 1'b0 || frame_ok !== 1'b0) begin
      errors++; $display("FAIL reset_frame: done=%b ok=%b want 0 0", frame_done, frame_ok);
    end
    checks++;
    if (good_count !== 16'd0 || bad_count !== 16'd0 || resync_count !== 16'd0) begin
      errors++; $display("FAIL reset_counts: g=%0d b=%0d r=%0d want 0 0 0",
                         good_count, bad_count, resync_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_hunt_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_good_frame();
    do_reset();
    drive_word(32'hA55A0002, 1'b0, 0, 0);
    drive_word(32'h00000001, 1'b0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_last !== 1'b0 || out_data !== 32'h1) begin
      errors++; $display("FAIL good_word0: v=%b last=%b data=%h want 1 0 1",
                         out_valid, out_last, out_data);
    end
    drive_word(32'h00000002, 1'b0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_last !== 1'b1 || out_data !== 32'h2) begin
      errors++; $display("FAIL good_word1: v=%b last=%b data=%h want 1 1 2",
                         out_valid, out_last, out_data);
    end
    drive_word(32'h5AA5FFFB, 1'b0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (frame_done !== 1'b1 || frame_ok !== 1'b1) begin
      errors++; $display("FAIL good_verdict: done=%b ok=%b want 1 1", frame_done, frame_ok);
    end
    idle(2);
    checks++;
    if (good_count !== 16'd1 || bad_count !== 16'd0) begin
      errors++; $display("FAIL good_counts: g=%0d b=%0d want 1 0", good_count, bad_count);
    end
    checks++;
    if (o_out.size() != 2 || o_ok.size() != 1) begin
      errors++; $display("FAIL good_stream_len: outs=%0d verdicts=%0d want 2 1",
                         o_out.size(), o_ok.size());
    end
  endtask

  task automatic test_corrupt_trailer();
    do_reset();
    drive_word(32'hA55A0002, 1'b0, 0, 0);
    drive_word(32'h00000001, 1'b0, 0, 0);
    drive_word(32'h00000002, 1'b0, 0, 0);
    drive_word(32'h5AA5FFFC, 1'b0, 0, 0);
    idle(3);
    checks++;
    if (o_out.size() != 2 || o_out[0] !== {1'b0, 32'h1} || o_out[1] !== {1'b1, 32'h2}) begin
      errors++; $display("FAIL corrupt_payload: n=%0d want 2 words 1,2(last)", o_out.size());
    end
    checks++;
    if (o_ok.size() != 1 || o_ok[0] !== 1'b0) begin
      errors++; $display("FAIL corrupt_verdict: n=%0d want one verdict of 0", o_ok.size());
    end
    checks++;
    if (good_count !== 16'd0 || bad_count !== 16'd1) begin
      errors++; $display("FAIL corrupt_counts: g=%0d b=%0d want 0 1", good_count, bad_count);
    end
  endtask

  task automatic test_resync();
    do_reset();
    drive_word(32'h12345678, 1'b0, 0, 0);
    drive_word(32'hA55A0000, 1'b0, 0, 0);
    drive_word(32'hA55A0011, 1'b0, 0, 0);
    drive_word(32'hA55A0002, 1'b0, 0, 0);
    drive_word(32'h00000001, 1'b0, 0, 0);
    drive_word(32'h00000002, 1'b0, 0, 0);
    drive_word(32'h5AA5FFFB, 1'b0, 0, 0);
    idle(3);
    checks++;
    if (resync_count !== 16'd3) begin
      errors++; $display("FAIL resync_count: got %0d want 3", resync_count);
    end
    checks++;
    if (good_count !== 16'd1 || o_ok.size() != 1) begin
      errors++; $display("FAIL resync_good: g=%0d verdicts=%0d want 1 1", good_count, o_ok.size());
    end
    checks++;
    if (o_out.size() != 2 || o_out[1] !== {1'b1, 32'h2}) begin
      errors++; $display("FAIL resync_payload: n=%0d want 2 ending in 2(last)", o_out.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive_word(32'hA55A0002, 1'b0, 0, 0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h1; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h1) begin
        errors++; $display("FAIL stall_cycle%0d: in_ready=%b out_valid=%b out_data=%h want 0 1 1",
                           k, in_ready, out_valid, out_data);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    drive_word(32'h00000002, 1'b0, 0, 0);
    drive_word(32'h5AA5FFFB, 1'b0, 0, 0);
    idle(3);
    checks++;
    if (o_out.size() != 2 || o_out[0] !== {1'b0, 32'h1} || o_out[1] !== {1'b1, 32'h2}) begin
      errors++; $display("FAIL stall_stream: n=%0d want exactly 1 then 2(last)", o_out.size());
    end
    checks++;
    if (o_ok.size() != 1 || o_ok[0] !== 1'b1) begin
      errors++; $display("FAIL stall_verdict: n=%0d want one verdict of 1", o_ok.size());
    end
  endtask

  task automatic test_overflow_taint();
    do_reset();
    drive_word(32'hA55A0002, 1'b0, 0, 0);
    drive_word(32'h00000001, 1'b0, 0, 0);
    drive_word(32'h00000002, 1'b1, 0, 0);
    drive_word(32'h5AA5FFFB, 1'b1, 0, 0);
    idle(3);
    checks++;
    if (o_ok.size() != 1 || o_ok[0] !== 1'b0) begin
      errors++; $display("FAIL overflow_verdict: n=%0d want one verdict of 0", o_ok.size());
    end
    checks++;
    if (bad_count !== 16'd1 || good_count !== 16'd0) begin
      errors++; $display("FAIL overflow_counts: g=%0d b=%0d want 0 1", good_count, bad_count);
    end
  endtask

  task automatic test_reset_mid_payload();
    do_reset();
    drive_word(32'hA55A0002, 1'b0, 0, 0);
    drive_word(32'h00000001, 1'b0, 0, 0);
    drive_word(32'h12345678, 1'b0, 0, 0);
    // Bad trailer-free abandon: a garbage word is not sent; reset instead
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    o_out.delete(); o_ok.delete();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL midreset_hunt: in_ready=%b out_valid=%b done=%b want 1 0 0",
                         in_ready, out_valid, frame_done);
    end
    checks++;
    if (good_count !== 16'd0 || bad_count !== 16'd0 || resync_count !== 16'd0) begin
      errors++; $display("FAIL midreset_counts: g=%0d b=%0d r=%0d want 0 0 0",
                         good_count, bad_count, resync_count);
    end
    idle(2);
    checks++;
    if (o_ok.size() != 0) begin
      errors++; $display("FAIL midreset_no_done: got %0d verdicts want 0", o_ok.size());
    end
    drive_word(32'hA55A0002, 1'b0, 0, 0);
    drive_word(32'h00000001, 1'b0, 0, 0);
    drive_word(32'h00000002, 1'b0, 0, 0);
    drive_word(32'h5AA5FFFB, 1'b0, 0, 0);
    idle(3);
    checks++;
    if (o_ok.size() != 1 || o_ok[0] !== 1'b1 || good_count !== 16'd1) begin
      errors++; $display("FAIL midreset_next_frame: verdicts=%0d g=%0d want one ok, g=1",
                         o_ok.size(), good_count);
    end
  endtask

  // Random mix of garbage, bad headers, good and corrupt frames; model works per item
  task automatic test_random_streams(input int stall_pct, input int gap_pct, input int items);
    logic [31:0] w[$];
    bit          ov[$];
    int          exp_resync, exp_good, exp_bad, kind, n;
    logic [31:0] word, sum;
    bit          corrupt, tainted, f;
    do_reset();
    exp_resync = 0; exp_good = 0; exp_bad = 0;
    for (int it = 0; it < items; it++) begin
      kind = int'($urandom_range(3));
      if (kind == 0) begin
        word = $urandom;
        if (word[31:16] == MAGIC) word[31:16] = 16'h1234;
        w.push_back(word); ov.push_back($urandom_range(9) == 0);
        exp_resync++;
      end else if (kind == 1) begin
        n = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(65535, 17));
        word = {MAGIC, 16'(n)};
        w.push_back(word); ov.push_back(1'b0);
        exp_resync++;
      end else begin
        n = int'($urandom_range(16, 1));
        corrupt = ($urandom_range(3) == 0);
        word = {MAGIC, 16'(n)};
        sum = word;
        f = ($urandom_range(19) == 0); tainted = f;
        w.push_back(word); ov.push_back(f);
        for (int k = 0; k < n; k++) begin
          word = ($urandom_range(7) == 0) ? 32'hA55A0003 : $urandom;
          sum = sum + word;
          f = ($urandom_range(19) == 0); tainted = tainted | f;
          w.push_back(word); ov.push_back(f);
          m_out.push_back({(k == n - 1), word});
        end
        word = 32'd0 - sum;
        if (corrupt) word = word + 32'($urandom_range(255, 1));
        f = ($urandom_range(19) == 0); tainted = tainted | f;
        w.push_back(word); ov.push_back(f);
        m_ok.push_back(!corrupt && !tainted);
        if (!corrupt && !tainted) exp_good++;
        else exp_bad++;
      end
    end
    for (int i = 0; i < w.size(); i++) drive_word(w[i], ov[i], stall_pct, gap_pct);
    idle(4);
    checks++;
    if (o_out.size() != m_out.size()) begin
      errors++; $display("FAIL rand_out_len: got %0d want %0d", o_out.size(), m_out.size());
    end
    for (int i = 0; i < o_out.size() && i < m_out.size(); i++) begin
      checks++;
      if (o_out[i] !== m_out[i]) begin
        errors++; $display("FAIL rand_out[%0d]: got last=%b data=%h want last=%b data=%h",
                           i, o_out[i][32], o_out[i][31:0], m_out[i][32], m_out[i][31:0]);
      end
    end
    checks++;
    if (o_ok.size() != m_ok.size()) begin
      errors++; $display("FAIL rand_verdict_len: got %0d want %0d", o_ok.size(), m_ok.size());
    end
    for (int i = 0; i < o_ok.size() && i < m_ok.size(); i++) begin
      checks++;
      if (o_ok[i] !== m_ok[i]) begin
        errors++; $display("FAIL rand_verdict[%0d]: got %b want %b", i, o_ok[i], m_ok[i]);
      end
    end
    checks++;
    if (good_count !== 16'(exp_good) || bad_count !== 16'(exp_bad) ||
        resync_count !== 16'(exp_resync)) begin
      errors++; $display("FAIL rand_counts: g=%0d b=%0d r=%0d want %0d %0d %0d",
                         good_count, bad_count, resync_count, exp_good, exp_bad, exp_resync);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_overflow = 1'b0; out_ready = 1'b1;
    test_reset();
    test_good_frame();
    test_corrupt_trailer();
    test_resync();
    test_backpressure();
    test_overflow_taint();
    test_reset_mid_payload();
    test_random_streams(0, 0, 40);
    test_random_streams(40, 0, 40);
    test_random_streams(30, 30, 40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
